// File: rtl/vmicro16_mem_arbiter.sv
// vmicro16_mem_arbiter
//
// Round-robin arbiter that shares one single-port scratch BRAM between
// NUM_REQ requesters (cores or DMA). Each access passes through IDLE
// (arbitrate and latch), ACCESS (drive the BRAM) and RESP (acknowledge and
// return read data). RESP absorbs the BRAM's one-cycle synchronous read
// latency.
//
// Optional feature: define VMICRO16_ARB_LOCK_EN to add the req_lock port.
// With the lock, a requester can hold the bus across several accesses, for
// example an atomic LW/SW pair on a semaphore.
//
// Ports
//   clk, reset  clock; synchronous active-high reset
//   req_valid   per-requester request pending
//   req_we      per-requester write enable (1 = write)
//   req_addr    packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata   packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_lock    per-requester bus lock request (VMICRO16_ARB_LOCK_EN only)
//   req_ack     one-cycle completion pulse, at most one bit set
//   req_rdata   read data, valid while a read's ack is high, otherwise 0
//   grant_id    index of the current or most recent grant
//   mem_addr, mem_in, mem_we   to the BRAM
//   mem_out                    from the BRAM (registered read data)
module vmicro16_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_BITS   = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
`ifdef VMICRO16_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock,
`endif
  output logic [NUM_REQ-1:0]               req_ack,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [SEL_BITS-1:0]              grant_id,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_in,
  output logic                             mem_we,
  input  logic [DATA_WIDTH-1:0]            mem_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [SEL_BITS-1:0]     last_grant_q, last_grant_d;
  logic [SEL_BITS-1:0]     grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;

  logic [NUM_REQ-1:0]      cand;
  logic                    found;
  logic [SEL_BITS-1:0]     pick;
  int                      scan_idx;

`ifdef VMICRO16_ARB_LOCK_EN
  logic                    lock_q, lock_d;
  logic [SEL_BITS-1:0]     owner_q, owner_d;

  // While locked only the owner may be granted; everyone else stalls.
  always_comb begin
    cand    = lock_q ? (req_valid & (ONE_HOT0 << owner_q)) : req_valid;
    lock_d  = lock_q;
    owner_d = owner_q;
    if (state_q == S_RESP) begin
      if (req_lock[grant_q]) begin
        lock_d  = 1'b1;
        owner_d = grant_q;
      end else if (lock_q && (grant_q == owner_q)) begin
        lock_d = 1'b0;
      end
    end else if ((state_q == S_IDLE) && lock_q && !req_lock[owner_q]) begin
      lock_d = 1'b0;
    end
  end
`else
  always_comb begin
    cand = req_valid;
  end
`endif

  // Round-robin scan starting just after the previous winner, wrapping at NUM_REQ.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (!found && cand[scan_idx]) begin
        found = 1'b1;
        pick  = SEL_BITS'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d      = req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          we_d         = req_we[pick];
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Reset starts the scan so that requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= SEL_BITS'(NUM_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
`ifdef VMICRO16_ARB_LOCK_EN
      lock_q       <= 1'b0;
      owner_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
`ifdef VMICRO16_ARB_LOCK_EN
      lock_q       <= lock_d;
      owner_q      <= owner_d;
`endif
    end
  end

  // Outputs are gated by reset so an aborted access never writes or acks.
  assign mem_addr  = addr_q;
  assign mem_in    = wdata_q;
  assign mem_we    = (state_q == S_ACCESS) && we_q && !reset;
  assign grant_id  = grant_q;
  assign req_ack   = ((state_q == S_RESP) && !reset) ? (ONE_HOT0 << grant_q) : '0;
  assign req_rdata = ((state_q == S_RESP) && !we_q && !reset) ? mem_out : '0;

endmodule

// File: tb/tb_vmicro16_mem_arbiter.sv
module tb_vmicro16_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
`ifdef VMICRO16_ARB_LOCK_EN
  logic [3:0]  req_lock;
`endif
  logic [3:0]  req_ack;
  logic [15:0] req_rdata;
  logic [1:0]  grant_id;
  logic [15:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_we;
  logic [15:0] mem_out;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:65535];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vmicro16_mem_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef VMICRO16_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ack(req_ack), .req_rdata(req_rdata), .grant_id(grant_id),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we),
    .mem_out(mem_out)
  );

  // Single-port BRAM model with a synchronous read and a bench preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_in;
    mem_out <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [15:0] a, input logic [15:0] d);
    req_valid[i]        = v;
    req_we[i]           = we;
    req_addr[i*16 +: 16]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  // Advance until an ack appears (bounded), checking one-hot every cycle,
  // then check latency in clock edges and which requester was acked.
  task automatic wait_ack(input int idx, input int exp_lat, input string tag);
    int lat;
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk({tag, "_onehot"}, 32'($onehot0(req_ack)), 32'd1);
      if (req_ack != 4'b0000) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ack"}, 32'(req_ack), 32'(4'b0001 << idx));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef VMICRO16_ARB_LOCK_EN
    req_lock  = '0;
`endif
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    tick();
    tick();
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", 32'(req_rdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;

    preload(16'd5, 16'h1234);
    preload(16'd7, 16'h7777);
    for (int i = 0; i < 4; i++) preload(16'(16'h10 + i), 16'(16'hA000 + i));

    // Read, then write, then read back.
    set_req(0, 1'b1, 1'b0, 16'd5, 16'h0);
    wait_ack(0, 2, "t1_rd");
    chk("t1_rdata", 32'(req_rdata), 32'h1234);
    set_req(0, 1'b0, 1'b0, 16'd0, 16'h0);
    tick();
    set_req(2, 1'b1, 1'b1, 16'd9, 16'hBEEF);
    tick();
    chk("t1_we_access", 32'(mem_we), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd9);
    chk("t1_din", 32'(mem_in), 32'hBEEF);
    chk("t1_grant", 32'(grant_id), 32'd2);
    tick();
    chk("t1_wr_ack", 32'(req_ack), 32'b0100);
    chk("t1_we_resp", 32'(mem_we), 32'd0);
    chk("t1_wr_rdata", 32'(req_rdata), 32'd0);
    set_req(2, 1'b0, 1'b0, 16'd0, 16'h0);
    tick();
    chk("t1_we_idle", 32'(mem_we), 32'd0);
    set_req(1, 1'b1, 1'b0, 16'd9, 16'h0);
    wait_ack(1, 2, "t1_rb");
    chk("t1_rb_data", 32'(req_rdata), 32'hBEEF);
    set_req(1, 1'b0, 1'b0, 16'd0, 16'h0);
    tick();

    // Round-robin with everyone valid, starting from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'(16'h10 + i), 16'h0);
    for (int k = 0; k < 12; k++) begin
      wait_ack(k % 4, (k == 0) ? 2 : 3, "t2");
      chk("t2_rdata", 32'(req_rdata), 32'(16'hA000 + (k % 4)));
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Wrap-around: last grant 2, then only 3 and 0 compete.
    set_req(2, 1'b1, 1'b0, 16'h12, 16'h0);
    wait_ack(2, 2, "t3_pre");
    set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    set_req(3, 1'b1, 1'b0, 16'h13, 16'h0);
    set_req(0, 1'b1, 1'b0, 16'h10, 16'h0);
    wait_ack(3, 2, "t3_a");
    chk("t3_grant_a", 32'(grant_id), 32'd3);
    wait_ack(0, 3, "t3_b");
    chk("t3_grant_b", 32'(grant_id), 32'd0);
    wait_ack(3, 3, "t3_c");
    set_req(3, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Reset during ACCESS of a write to addr 7.
    set_req(1, 1'b1, 1'b1, 16'd7, 16'hDEAD);
    tick();
    chk("t4_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_we_rst", 32'(mem_we), 32'd0);
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    chk("t4_ack", 32'(req_ack), 32'd0);
    chk("t4_grant", 32'(grant_id), 32'd0);
    chk("t4_we_post", 32'(mem_we), 32'd0);
    reset = 1'b0;
    tick();
    chk("t4_ack_idle", 32'(req_ack), 32'd0);
    set_req(0, 1'b1, 1'b0, 16'd7, 16'h0);
    wait_ack(0, 2, "t4_rd");
    chk("t4_mem7", 32'(req_rdata), 32'h7777);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();

    // Idle bus for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t6_we", 32'(mem_we), 32'd0);
      chk("t6_ack", 32'(req_ack), 32'd0);
      chk("t6_grant", 32'(grant_id), 32'd0);
    end

`ifdef VMICRO16_ARB_LOCK_EN
    // Requester 1 locks for read-modify-write of addr 3 while 0 waits.
    set_req(1, 1'b1, 1'b0, 16'd3, 16'h0);
    req_lock[1] = 1'b1;
    tick();
    set_req(0, 1'b1, 1'b0, 16'h10, 16'h0);
    wait_ack(1, 1, "t5_rd");
    set_req(1, 1'b1, 1'b1, 16'd3, 16'h5A5A);
    req_lock[1] = 1'b0;
    wait_ack(1, 3, "t5_wr");
    set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_ack(0, 3, "t5_r0");
    chk("t5_r0_data", 32'(req_rdata), 32'hA000);
    set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    set_req(2, 1'b1, 1'b0, 16'd3, 16'h0);
    wait_ack(2, 2, "t5_chk");
    chk("t5_mem3", 32'(req_rdata), 32'h5A5A);
    set_req(2, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
